// File: rtl/dir_ctrl.sv
// -----------------------------------------------------------------------------
// dir_ctrl: snake direction controller.
//
// Takes the debounced one-cycle key pulses for the four direction buttons. It
// keeps a small FIFO of pending turns and applies one turn per game step
// (tick). It also owns the IDLE/RUN game state.
//
// Key handling:
//   - Simultaneous keys are arbitrated with priority up > down > left > right.
//   - No-op and 180-degree reversal turns are discarded. They are compared
//     against the last queued turn, or against the current direction when the
//     queue is empty.
//
// Direction encoding: 0=up, 1=down, 2=left, 3=right.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_*_v      one-cycle key pulses (up/down/left/right)
//   tick         one-cycle pulse per snake step
//   game_over    forces IDLE, flushes the queue, restores INIT_DIR
//   dir          currently applied direction (registered)
//   running      high in RUN (registered)
//   dir_changed  one-cycle pulse when a tick applies a queued turn
//   key_drop     one-cycle pulse when a valid key meets a full queue
//   q_cnt        number of queued turns
// -----------------------------------------------------------------------------
module dir_ctrl #(
    parameter int         DEPTH    = 2,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_v,
    input  logic       key_down_v,
    input  logic       key_left_v,
    input  logic       key_right_v,
    input  logic       tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       running,
    output logic       dir_changed,
    output logic       key_drop,
    output logic [2:0] q_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

    // Reversal partner: up<->down and left<->right differ only in bit 0.
    function automatic logic [1:0] rev_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == LAST_PTR) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    function automatic logic [1:0] ptr_dec(input logic [1:0] p);
        if (p == 2'd0) begin
            return LAST_PTR;
        end else begin
            return p - 2'd1;
        end
    endfunction

    // Storage is sized for the maximum depth. This keeps the 2-bit pointers
    // exactly matched to the array; only the first DEPTH entries are used.
    state_t     state_q, state_d;
    logic [1:0] queue_q [4];
    logic [1:0] queue_d [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] q_cnt_q, q_cnt_d;
    logic [1:0] dir_q, dir_d;
    logic       running_q, running_d;
    logic       dir_changed_q, dir_changed_d;
    logic       key_drop_q, key_drop_d;

    logic       key_v_s;
    logic [1:0] key_k_s;
    logic [1:0] ref_dir_s;
    logic       key_ok_s;
    logic       push_s;
    logic       pop_s;

    // Fixed-priority key arbitration; losing keys vanish silently.
    always_comb begin
        key_v_s = 1'b1;
        key_k_s = 2'd0;
        if (key_up_v) begin
            key_k_s = 2'd0;
        end else if (key_down_v) begin
            key_k_s = 2'd1;
        end else if (key_left_v) begin
            key_k_s = 2'd2;
        end else if (key_right_v) begin
            key_k_s = 2'd3;
        end else begin
            key_v_s = 1'b0;
        end
    end

    // Filter the selected key against the direction the snake will have once
    // all queued turns are applied.
    always_comb begin
        if (q_cnt_q != 3'd0) begin
            ref_dir_s = queue_q[ptr_dec(wr_ptr_q)];
        end else begin
            ref_dir_s = dir_q;
        end
        key_ok_s = key_v_s && (key_k_s != ref_dir_s) && (key_k_s != rev_dir(ref_dir_s));
    end

    // Next-state logic: game state, queue push/pop, direction update.
    always_comb begin
        state_d       = state_q;
        queue_d       = queue_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        q_cnt_d       = q_cnt_q;
        dir_d         = dir_q;
        running_d     = running_q;
        dir_changed_d = 1'b0;
        key_drop_d    = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;

        if (game_over) begin
            state_d   = ST_IDLE;
            running_d = 1'b0;
            rd_ptr_d  = 2'd0;
            wr_ptr_d  = 2'd0;
            q_cnt_d   = 3'd0;
            dir_d     = INIT_DIR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_ok_s) begin
                        push_s    = 1'b1;
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    // Popping first lets a full queue accept a key on the same tick.
                    pop_s = tick && (q_cnt_q != 3'd0);
                    if (key_ok_s) begin
                        if ((q_cnt_q < DEPTH_C) || pop_s) begin
                            push_s = 1'b1;
                        end else begin
                            key_drop_d = 1'b1;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    running_d = 1'b0;
                end
            endcase

            if (pop_s) begin
                dir_d         = queue_q[rd_ptr_q];
                rd_ptr_d      = ptr_inc(rd_ptr_q);
                dir_changed_d = 1'b1;
            end else begin
                dir_changed_d = 1'b0;
            end

            if (push_s) begin
                queue_d[wr_ptr_q] = key_k_s;
                wr_ptr_d          = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   q_cnt_d = q_cnt_q + 3'd1;
                2'b01:   q_cnt_d = q_cnt_q - 3'd1;
                default: q_cnt_d = q_cnt_q;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                queue_q[i] <= 2'd0;
            end
            rd_ptr_q      <= 2'd0;
            wr_ptr_q      <= 2'd0;
            q_cnt_q       <= 3'd0;
            dir_q         <= INIT_DIR;
            running_q     <= 1'b0;
            dir_changed_q <= 1'b0;
            key_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            queue_q       <= queue_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            q_cnt_q       <= q_cnt_d;
            dir_q         <= dir_d;
            running_q     <= running_d;
            dir_changed_q <= dir_changed_d;
            key_drop_q    <= key_drop_d;
        end
    end

    assign dir         = dir_q;
    assign running     = running_q;
    assign dir_changed = dir_changed_q;
    assign key_drop    = key_drop_q;
    assign q_cnt       = q_cnt_q;

endmodule

// File: tb/tb_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dir_ctrl: table-driven self-checking bench for dir_ctrl.
//
// Configuration under test: DEPTH=2, INIT_DIR=right.
//
// Flow:
//   - Each vector is driven for one cycle at the falling edge.
//   - Its expected outputs are pushed to a scoreboard queue at the same time.
//   - The expected outputs are popped and compared just after the next rising
//     edge.
//   - Asynchronous reset in mid-operation is exercised by a hand-written
//     sequence.
//
// Key field of a vector: {up, down, left, right}.
// -----------------------------------------------------------------------------
module tb_dir_ctrl;

    typedef struct {
        logic [3:0] keys;
        logic       tick;
        logic       go;
        logic [1:0] e_dir;
        logic       e_run;
        logic       e_chg;
        logic       e_drop;
        logic [2:0] e_cnt;
    } vec_t;

    localparam logic [3:0] K0 = 4'b0000;
    localparam logic [3:0] KU = 4'b1000;
    localparam logic [3:0] KD = 4'b0100;
    localparam logic [3:0] KL = 4'b0010;
    localparam logic [3:0] KR = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_v = 1'b0, key_down_v = 1'b0, key_left_v = 1'b0, key_right_v = 1'b0;
    logic       tick = 1'b0, game_over = 1'b0;
    logic [1:0] dir;
    logic       running, dir_changed, key_drop;
    logic [2:0] q_cnt;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    dir_ctrl #(.DEPTH(2), .INIT_DIR(2'd3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_up_v    (key_up_v),
        .key_down_v  (key_down_v),
        .key_left_v  (key_left_v),
        .key_right_v (key_right_v),
        .tick        (tick),
        .game_over   (game_over),
        .dir         (dir),
        .running     (running),
        .dir_changed (dir_changed),
        .key_drop    (key_drop),
        .q_cnt       (q_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] k, input logic t, input logic g,
                                input logic [1:0] d, input logic r, input logic c,
                                input logic dr, input logic [2:0] n);
        vec_t v;
        v.keys = k;  v.tick = t;  v.go = g;
        v.e_dir = d; v.e_run = r; v.e_chg = c; v.e_drop = dr; v.e_cnt = n;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".dir"},         int'(dir),         int'(e.e_dir));
        chk({tag, ".running"},     int'(running),     int'(e.e_run));
        chk({tag, ".dir_changed"}, int'(dir_changed), int'(e.e_chg));
        chk({tag, ".key_drop"},    int'(key_drop),    int'(e.e_drop));
        chk({tag, ".q_cnt"},       int'(q_cnt),       int'(e.e_cnt));
    endtask

    // Drive one vector, record its expectation, then check after the edge.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        {key_up_v, key_down_v, key_left_v, key_right_v} = v.keys;
        tick      = v.tick;
        game_over = v.go;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_all(tag, e);
    endtask

    initial begin
        //                    keys tick go  dir   run   chg   drop  cnt
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 0  idle tick ignored
        vecs.push_back(mk(KR,    1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 1  same dir rejected
        vecs.push_back(mk(KL,    1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 2  reversal rejected
        vecs.push_back(mk(KU,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd1)); // 3  start game
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0)); // 4  apply up
        vecs.push_back(mk(KR,    1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1)); // 5  queue right
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 3'd0)); // 6  apply right
        vecs.push_back(mk(KL,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0)); // 7  reversal rejected
        vecs.push_back(mk(KR,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0)); // 8  no-op rejected
        vecs.push_back(mk(KU,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd1)); // 9
        vecs.push_back(mk(KL,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd2)); // 10 ref=up, left ok
        vecs.push_back(mk(KD,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 3'd2)); // 11 full -> drop
        vecs.push_back(mk(K0,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd2)); // 12 drop is a pulse
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd1)); // 13 apply up
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0)); // 14 apply left
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0)); // 15 tick, empty queue
        vecs.push_back(mk(KU,    1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd1)); // 16
        vecs.push_back(mk(KL,    1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd2)); // 17 full, tail=left
        vecs.push_back(mk(KD,    1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd2)); // 18 pop+push, no drop
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd1)); // 19 apply left
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0)); // 20 apply down
        vecs.push_back(mk(KR,    1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd1)); // 21
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 3'd0)); // 22 apply right
        vecs.push_back(mk(KU|KL, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd1)); // 23 up wins
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0)); // 24 apply up
        vecs.push_back(mk(KU|KL, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0)); // 25 up wins, rejected
        vecs.push_back(mk(KL|KR, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1)); // 26 left wins
        vecs.push_back(mk(KD,    1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd2)); // 27 ref=left
        vecs.push_back(mk(KR,    1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 28 game_over wins
        vecs.push_back(mk(K0,    1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 29 idle tick
        vecs.push_back(mk(KU,    1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0)); // 30 key lost to game_over
        vecs.push_back(mk(KD,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd1)); // 31 restart
        vecs.push_back(mk(KL,    1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd2)); // 32
        vecs.push_back(mk(KU,    1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd2)); // 33 pop down, push up

        // Reset state, sampled between edges.
        #12;
        chk_all("reset", mk(K0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-operation: dir=down, pulse high, queue full.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", mk(K0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        {key_up_v, key_down_v, key_left_v, key_right_v} = K0;
        tick = 1'b0;
        game_over = 1'b0;
        rst_n = 1'b1;
        // After reset the queue must be empty with pointers aligned.
        apply("post_rst_key",  mk(KD, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd1));
        apply("post_rst_tick", mk(K0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0));
        apply("post_rst_idle", mk(K0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd0));

        if (exp_q.size() != 0) begin
            chk("scoreboard_empty", exp_q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dir_ctrl.md
Name: dir_ctrl

Overview:
- Consumes the one-cycle debounced key pulses produced by keycheck for the four direction buttons.
- Buffers pending turns in a small FIFO and filters out no-op and 180° reversal requests.
- Applies one turn per game step tick and drives the snake direction used by the movement logic.
- Also owns the IDLE/RUN game-start state: the first valid key starts the game, and game_over returns the block to IDLE.

Parameters:
- DEPTH, 2, turn-queue depth in entries; legal range 1..4.
- INIT_DIR, 2'd3, direction after reset or game_over. Encoding: 0=up, 1=down, 2=left, 3=right.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_up_v  in  1  one-cycle pulse from keycheck, up button
- key_down_v  in  1  one-cycle pulse, down button
- key_left_v  in  1  one-cycle pulse, left button
- key_right_v  in  1  one-cycle pulse, right button
- tick  in  1  one-cycle pulse, once per snake step
- game_over  in  1  level or pulse; forces IDLE
- dir  out  2  current applied direction
- running  out  1  high in RUN state
- dir_changed  out  1  one-cycle pulse when dir is updated by a tick
- key_drop  out  1  one-cycle pulse when a key is discarded because the queue is full
- q_cnt  out  3  number of queued turns

Behaviour:
- Clock, reset and output registration:
  - One clock; reset is asynchronous and active-low.
  - All outputs are registered.
  - Reset values: dir=INIT_DIR, running=0, dir_changed=0, key_drop=0, q_cnt=0, queue emptied, state=IDLE.
- Key arbitration: if several key pulses are asserted in the same cycle, only one is taken, with priority up > down > left > right. The others are silently ignored and do not assert key_drop.
- Reference direction: ref = last queued entry when q_cnt>0, otherwise dir.
- Key filtering: the selected key k is rejected silently if k==ref or k==reverse(ref). Reverse pairs are up/down and left/right. A rejected key does not assert key_drop.
- IDLE state:
  - tick is ignored.
  - A valid (non-rejected) key sets running=1 on the next cycle and enqueues k.
  - The transition goes to RUN.
- RUN state, enqueue: a valid key is enqueued when q_cnt<DEPTH.
- RUN state, queue full: if q_cnt==DEPTH and tick is low, the key is dropped and key_drop pulses on the next cycle.
- RUN state, tick with q_cnt>0:
  - The head entry is popped.
  - dir takes the head value on the next cycle.
  - dir_changed pulses on the same cycle that dir updates.
- RUN state, tick with q_cnt==0: dir is held and dir_changed stays 0.
- Simultaneous tick and key:
  - The pop takes effect first, so a full queue accepts the key with no drop.
  - ref is evaluated before the pop. This is consistent, because the popped head becomes dir.
  - q_cnt is unchanged net.
- game_over:
  - Has highest priority over keys and tick, in both states.
  - Next cycle: state=IDLE, running=0, queue flushed, q_cnt=0, dir=INIT_DIR, dir_changed=0, key_drop=0.
  - Keys presented in the same cycle as game_over are discarded.
- Queue structure:
  - Circular buffer with a read pointer and a write pointer, each wrapping modulo DEPTH.
  - q_cnt never exceeds DEPTH and never underflows.
- Asynchronous reset asserted mid-operation returns every register immediately to its reset value.
- Latency:
  - From a key pulse to q_cnt/running update: 1 cycle.
  - From tick to dir/dir_changed update: 1 cycle.

Test Plan:
- Reset, then key_up_v pulse in IDLE with INIT_DIR=right → running=1 and q_cnt=1 next cycle. The next tick gives dir=0 (up) and a single dir_changed pulse.
- RUN with dir=right, pulse key_left_v then key_right_v → both rejected: q_cnt stays 0, no key_drop, dir stays 3.
- RUN with dir=right, pulse key_up_v, key_left_v, key_down_v on separate cycles with no tick (DEPTH=2):
  - up and left are queued, giving q_cnt=2.
  - down is dropped with a key_drop pulse.
  - The following two ticks yield dir=0, then dir=2.
- Queue full (q_cnt=2, tail=left) with key_down_v and tick in the same cycle → head popped and down enqueued. Result: q_cnt=2, no key_drop, dir takes the old head.
- Keys key_up_v and key_left_v in the same cycle with dir=right → only up is enqueued (q_cnt=1). The next tick gives dir=0.
- game_over asserted with q_cnt=2 and dir=up → next cycle running=0, q_cnt=0, dir=3. A subsequent tick without a key leaves dir=3 and dir_changed=0.
